// File: rtl/tx_frame_builder.sv
// tx_frame_builder: RMII transmit framer adding preamble/SFD, optional zero pad (TX_PAD_EN), CRC32 FCS and inter-frame gap
module tx_frame_builder #(
  parameter int PREAMBLE_DIBITS   = 32,
  parameter int MIN_PAYLOAD_BYTES = 60,
  parameter int IFG_DIBITS        = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiir,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IFG} state_t;
  localparam logic [5:0]  PRE_LAST   = 6'(PREAMBLE_DIBITS - 1);
  localparam logic [5:0]  IFG_LAST   = 6'(IFG_DIBITS - 2);
  localparam logic [13:0] MIN_DIBITS = 14'(MIN_PAYLOAD_BYTES * 4);
  state_t      state_q, state_d, eff;
  logic [5:0]  idx_q, idx_d;
  logic [13:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] crc_q, crc_d;
  logic        axiov_q, axiov_d, done_q, done_d, pad_req;
  logic [1:0]  axiod_q, axiod_d;
  function automatic logic [31:0] crc2(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`ifdef TX_PAD_EN
  assign pad_req = cnt_q < MIN_DIBITS;
`else
  logic unused_min;
  assign unused_min = cnt_q < MIN_DIBITS;
  assign pad_req    = 1'b0;
`endif
  assign cnt_inc    = &cnt_q ? cnt_q : cnt_q + 14'd1;
  // The end-of-payload cycle already behaves as PAD/FCS so axiov has no bubble
  assign eff        = (state_q == PAYLOAD && !axiiv) ? (pad_req ? PAD : FCS) : state_q;
  assign axiir      = state_q == PAYLOAD && axiiv;
  assign busy       = state_q != IDLE;
  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign frame_done = done_q;
  // Next-state, counters, CRC and next wire dibit
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    axiov_d = 1'b0;
    axiod_d = 2'b00;
    done_d  = 1'b0;
    case (eff)
      IDLE: if (axiiv) begin
        state_d = PREAMBLE;
        idx_d   = '0;
        cnt_d   = '0;
        crc_d   = '1;
      end
      PREAMBLE: begin
        axiov_d = 1'b1;
        axiod_d = idx_q == PRE_LAST ? 2'b11 : 2'b01;
        idx_d   = idx_q == PRE_LAST ? 6'd0 : idx_q + 6'd1;
        state_d = idx_q == PRE_LAST ? PAYLOAD : PREAMBLE;
      end
      PAYLOAD: begin
        axiov_d = 1'b1;
        axiod_d = axiid;
        crc_d   = crc2(crc_q, axiid);
        cnt_d   = cnt_inc;
      end
`ifdef TX_PAD_EN
      PAD: begin
        axiov_d = 1'b1;
        crc_d   = crc2(crc_q, 2'b00);
        cnt_d   = cnt_inc;
        state_d = cnt_inc == MIN_DIBITS ? FCS : PAD;
      end
`endif
      FCS: begin
        axiov_d = 1'b1;
        axiod_d = ~crc_q[{idx_q[3:0], 1'b0} +: 2];
        done_d  = idx_q[3:0] == 4'hF;
        idx_d   = done_d ? 6'd0 : idx_q + 6'd1;
        state_d = done_d ? IFG : FCS;
      end
      IFG: begin
        idx_d   = idx_q == IFG_LAST ? 6'd0 : idx_q + 6'd1;
        state_d = idx_q == IFG_LAST ? IDLE : IFG;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and registered pin outputs; reset aborts any frame at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      crc_q   <= '1;
      axiov_q <= 1'b0;
      axiod_q <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      axiov_q <= axiov_d;
      axiod_q <= axiod_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_tx_frame_builder.sv
// tb_tx_frame_builder: scoreboard bench for tx_frame_builder wire output
module tb_tx_frame_builder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic       axiir, axiov, busy, frame_done;
  logic [1:0] axiod;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] pay_q[$];
  logic [2:0] exp_q[$];
  bit         in_frame = 0;
  int         gap = 0;
  int         last_gap = -1;

  tx_frame_builder dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiir(axiir),
    .axiov(axiov), .axiod(axiod), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input int nb);
    logic [31:0] c;
    logic [7:0]  b;
    c = '1;
    for (int k = 0; k < nb; k++) begin
      b = (k < pay_q.size()) ? pay_q[k] : 8'h00;
      c = c ^ {24'h0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_exp(input logic [31:0] hint, input bit hint_ok);
    int          nb;
    logic [7:0]  b;
    logic [31:0] f;
    for (int i = 0; i < 32; i++) exp_q.push_back({1'b0, i == 31 ? 2'b11 : 2'b01});
    nb = pay_q.size();
`ifdef TX_PAD_EN
    if (nb < 60) nb = 60;
`endif
    for (int k = 0; k < nb; k++) begin
      b = (k < pay_q.size()) ? pay_q[k] : 8'h00;
      for (int j = 0; j < 4; j++) exp_q.push_back({1'b0, b[2*j +: 2]});
    end
    f = (hint_ok && nb == pay_q.size()) ? hint : ref_crc(nb);
    for (int j = 0; j < 16; j++) exp_q.push_back({j == 15, f[2*j +: 2]});
  endtask

  task automatic drive(input int abort_at);
    int         nd, i, t;
    logic [7:0] b;
    nd = pay_q.size() * 4;
    b = nd != 0 ? pay_q[0] : 8'h00;
    axiid = b[1:0];
    axiiv = 1'b1;
    i = 0;
    t = 0;
    if (nd == 0) begin
      do begin @(negedge clk); t++; end while (!axiov && t < 300);
      axiiv = 1'b0;
    end else begin
      while (i < nd && t < 2000) begin
        @(negedge clk);
        t++;
        if (axiir) begin
          @(posedge clk);
          #1;
          i++;
          if (i == abort_at) begin
            #2 rst = 1'b1;
            #1;
            chk("abort axiov", axiov, 0);
            chk("abort busy", busy, 0);
            chk("abort frame_done", frame_done, 0);
            axiiv = 1'b0;
            #3 rst = 1'b0;
            return;
          end
          if (i < nd) begin
            b = pay_q[i >> 2];
            axiid = b[(i % 4) * 2 +: 2];
          end else axiiv = 1'b0;
        end
      end
    end
    if (t >= 2000 || (nd == 0 && t >= 300)) begin
      n_chk++;
      n_fail++;
      $display("FAIL drive timeout: got %0d of %0d dibits consumed", i, nd);
      axiiv = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while ((busy || exp_q.size() != 0) && t < 3000);
    if (t >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle timeout: got busy=%0d pending=%0d required busy=0 pending=0", busy, exp_q.size());
    end
  endtask

  // Monitor: pop and compare every dibit the DUT puts on the wire
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      in_frame = 0;
    end else begin
      if (axiiv && !in_frame) chk("axiir held off", axiir, 0);
      if (axiov) begin
        if (exp_q.size() == 0) chk("unexpected axiov", axiov, 0);
        else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          chk("wire {frame_done,axiod}", {frame_done, axiod}, e);
          if (!in_frame) begin last_gap = gap; in_frame = 1; end
          if (e[2]) begin in_frame = 0; gap = 0; end
        end
      end else begin
        if (in_frame) begin chk("axiov bubble", axiov, 1); in_frame = 0; end
        if (frame_done) chk("frame_done without axiov", frame_done, 0);
        gap++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

  initial begin
    int t;
    #1 rst = 1'b1;
    #2;
    chk("reset axiov", axiov, 0);
    chk("reset axiod", axiod, 0);
    chk("reset axiir", axiir, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // "123456789": FCS CBF43926 when unpadded
    pay_q.delete();
    for (int k = 0; k < 9; k++) pay_q.push_back(8'(8'h31 + k));
    push_exp(32'hCBF43926, 1);
    drive(-1);
    wait_idle();
    // zero-length payload: FCS of empty message is 0
    pay_q.delete();
    push_exp(32'h00000000, 1);
    drive(-1);
    wait_idle();
    // 14-byte payload (padded to 60 bytes when TX_PAD_EN)
    pay_q.delete();
    for (int k = 0; k < 14; k++) pay_q.push_back(8'(k * 7 + 3));
    push_exp(32'h0, 0);
    drive(-1);
    wait_idle();
    // 64-byte payload, never padded
    pay_q.delete();
    for (int k = 0; k < 64; k++) pay_q.push_back(8'((k * 37) ^ 8'h5A));
    push_exp(32'h0, 0);
    drive(-1);
    wait_idle();
    // back-to-back: next frame requested during IFG
    pay_q.delete();
    for (int k = 0; k < 5; k++) pay_q.push_back(8'(8'hA0 + k));
    push_exp(32'h0, 0);
    drive(-1);
    t = 0;
    do begin @(negedge clk); t++; end while (!frame_done && t < 500);
    chk("b2b first frame_done", frame_done, 1);
    pay_q.delete();
    for (int k = 0; k < 9; k++) pay_q.push_back(8'(8'h31 + k));
    push_exp(32'hCBF43926, 1);
    drive(-1);
    wait_idle();
    chk("b2b idle gap", last_gap, 48);
    // async reset mid-payload, then a clean frame
    pay_q.delete();
    for (int k = 0; k < 20; k++) pay_q.push_back(8'(k + 8'h10));
    push_exp(32'h0, 0);
    @(posedge clk);
    #1;
    drive(20);
    repeat (3) @(posedge clk);
    #1;
    chk("post-abort busy", busy, 0);
    pay_q.delete();
    for (int k = 0; k < 9; k++) pay_q.push_back(8'(8'h31 + k));
    push_exp(32'hCBF43926, 1);
    drive(-1);
    wait_idle();
    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
